// File: rtl/fork_rr_scheduler.sv
// Round-robin scheduler sharing one four-phase fork channel among N_REQ requesters.
// The fork acknowledge is synchronized internally; a per-phase timer recovers stuck handshakes.
module fork_rr_scheduler #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned TW          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_vec,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             fork_req,
    input  logic             fork_ack,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned    PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TW-1:0]  TIMEOUT_T = TW'(TIMEOUT);
    localparam logic [PW-1:0]  PTR_RST   = PW'(N_REQ - 1);

    typedef enum logic [2:0] {StIdle, StRise, StFall, StDone, StErr} state_e;

    state_e                 state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   fork_req_q, fork_req_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    logic [N_REQ-1:0]       win_onehot;
    logic [PW-1:0]          win_idx;
    logic                   win_found;
    int unsigned            cand;
    logic [PW-1:0]          cand_idx;
    logic [TW-1:0]          timer_inc;
    logic                   timed_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fork_ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Search starts one past the last served owner and wraps modulo N_REQ.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_found  = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand     = (32'(ptr_q) + i) % N_REQ;
            cand_idx = PW'(cand);
            if (!win_found && req_vec[cand_idx]) begin
                win_found           = 1'b1;
                win_idx             = cand_idx;
                win_onehot[cand_idx] = 1'b1;
            end
        end
    end

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);
    assign timed_out = (TIMEOUT != 0) && (timer_inc >= TIMEOUT_T);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        fork_req_d    = fork_req_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found && !ack_s) begin
                    grant_d    = win_onehot;
                    owner_d    = win_idx;
                    fork_req_d = 1'b1;
                    timer_d    = '0;
                    state_d    = StRise;
                end
            end
            StRise: begin
                if (ack_s) begin
                    fork_req_d = 1'b0;
                    timer_d    = '0;
                    state_d    = StFall;
                end else if (timed_out) begin
                    fork_req_d    = 1'b0;
                    grant_d       = '0;
                    ptr_d         = owner_q;
                    timeout_err_d = 1'b1;
                    state_d       = StErr;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StFall: begin
                if (!ack_s) begin
                    state_d = StDone;
                end else if (timed_out) begin
                    grant_d       = '0;
                    ptr_d         = owner_q;
                    timeout_err_d = 1'b1;
                    state_d       = StErr;
                end else begin
                    timer_d = timer_inc;
                end
            end
            StDone: begin
                grant_d = '0;
                ptr_d   = owner_q;
                state_d = StIdle;
            end
            StErr: begin
                if (!ack_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                grant_d    = '0;
                fork_req_d = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            owner_q       <= '0;
            ptr_q         <= PTR_RST;
            fork_req_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            fork_req_q    <= fork_req_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
        end
    end

    assign grant       = grant_q;
    assign done        = (state_q == StDone) ? grant_q : '0;
    assign fork_req    = fork_req_q;
    assign busy        = (state_q != StIdle);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fork_rr_scheduler.sv
// Directed bench for fork_rr_scheduler with a behavioural four-phase fork that answers
// three cycles after each req edge; the ack can be forced high or disabled.
module tb_fork_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_vec = '0;
    logic [3:0] grant;
    logic [3:0] done;
    logic       fork_req;
    logic       fork_ack;
    logic       busy;
    logic       timeout_err;

    logic       ack_model;
    logic       force_ack = 1'b0;
    logic       model_en  = 1'b1;
    int         cnt;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] g;
    logic [3:0] d;
    logic [3:0] exp_rr [5];

    fork_rr_scheduler #(
        .N_REQ      (4),
        .SYNC_STAGES(2),
        .TIMEOUT    (10),
        .TW         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vec    (req_vec),
        .grant      (grant),
        .done       (done),
        .fork_req   (fork_req),
        .fork_ack   (fork_ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign fork_ack = force_ack | ack_model;

    // Fork model follows req three edges after any req/ack disagreement; reset with the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_model <= 1'b0;
            cnt       <= 0;
        end else if (!model_en) begin
            cnt <= 0;
        end else if (fork_req != ack_model) begin
            if (cnt == 2) begin
                ack_model <= fork_req;
                cnt       <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant, then for the done pulse; returns both and steps into IDLE.
    task automatic run_txn(input logic [3:0] after_req, output logic [3:0] gs,
                           output logic [3:0] ds);
        for (int i = 0; i < 40; i++) begin
            if (grant != 4'b0) break;
            tick();
        end
        gs      = grant;
        req_vec = after_req;
        for (int i = 0; i < 60; i++) begin
            if (done != 4'b0) break;
            tick();
        end
        ds = done;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_rr = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        #1 rst = 1'b0;
        #1;
        check_eq("rst_grant", grant, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_fork_req", fork_req, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_terr", timeout_err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single request, cycle-exact; request dropped right after grant is ignored.
        req_vec = 4'b0001;
        tick();
        check_eq("t1_grant", grant, 4'b0001);
        check_eq("t1_fork_req_up", fork_req, 1);
        check_eq("t1_busy", busy, 1);
        req_vec = 4'b0000;
        repeat (5) tick();
        check_eq("t1_fork_req_held", fork_req, 1);
        tick();
        check_eq("t1_fork_req_down", fork_req, 0);
        check_eq("t1_grant_held", grant, 4'b0001);
        repeat (5) tick();
        check_eq("t1_no_done_early", done, 0);
        tick();
        check_eq("t1_done", done, 4'b0001);
        tick();
        check_eq("t1_done_clear", done, 0);
        check_eq("t1_grant_clear", grant, 0);
        check_eq("t1_idle", busy, 0);

        // Round-robin with all requesters active; pointer now at requester 0.
        req_vec = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            run_txn((t == 4) ? 4'b0000 : 4'b1111, g, d);
            check_eq($sformatf("t2_grant%0d", t), g, exp_rr[t]);
            check_eq($sformatf("t2_done%0d", t), d, exp_rr[t]);
        end

        // Fairness: serve requester 2, then 0101 must go to requester 0 first.
        req_vec = 4'b0100;
        run_txn(4'b0000, g, d);
        check_eq("t3_serve2", g, 4'b0100);
        req_vec = 4'b0101;
        run_txn(4'b0101, g, d);
        check_eq("t3_fair0", g, 4'b0001);
        check_eq("t3_fair0_done", d, 4'b0001);
        run_txn(4'b0000, g, d);
        check_eq("t3_then2", g, 4'b0100);

        // Timeout: fork never acks; requester 3 times out, requester 0 is next.
        model_en = 1'b0;
        req_vec  = 4'b1111;
        tick();
        check_eq("t4_grant3", grant, 4'b1000);
        repeat (9) tick();
        check_eq("t4_fork_req_held", fork_req, 1);
        check_eq("t4_no_terr_yet", timeout_err, 0);
        tick();
        check_eq("t4_terr", timeout_err, 1);
        check_eq("t4_fork_req_low", fork_req, 0);
        check_eq("t4_grant_clear", grant, 0);
        check_eq("t4_no_done", done, 0);
        check_eq("t4_busy_err", busy, 1);
        model_en = 1'b1;
        tick();
        check_eq("t4_terr_pulse", timeout_err, 0);
        check_eq("t4_idle", busy, 0);
        check_eq("t4_no_done2", done, 0);
        tick();
        check_eq("t4_next_grant", grant, 4'b0001);
        run_txn(4'b0000, g, d);
        check_eq("t4_next_done", d, 4'b0001);

        // Stuck ack at idle blocks new grants until the synchronized ack clears.
        force_ack = 1'b1;
        tick();
        tick();
        req_vec = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("t5_blocked%0d", i), grant, 0);
        end
        check_eq("t5_not_busy", busy, 0);
        force_ack = 1'b0;
        tick();
        check_eq("t5_wait_sync1", grant, 0);
        tick();
        check_eq("t5_wait_sync2", grant, 0);
        tick();
        check_eq("t5_grant", grant, 4'b0010);
        run_txn(4'b0000, g, d);
        check_eq("t5_done", d, 4'b0010);

        // Asynchronous reset in RISE, then requester 0 regains top priority.
        req_vec = 4'b0100;
        tick();
        check_eq("t6_grant2", grant, 4'b0100);
        tick();
        #2 rst = 1'b0;
        #1;
        check_eq("t6_fork_req_async", fork_req, 0);
        check_eq("t6_grant_async", grant, 0);
        check_eq("t6_busy_async", busy, 0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        req_vec = 4'b1111;
        tick();
        check_eq("t6_prio0", grant, 4'b0001);
        run_txn(4'b0000, g, d);
        check_eq("t6_done0", d, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
